// File: rtl/tdc_measure.sv
// -----------------------------------------------------------------------------
// tdc_measure
//
// Purpose:
//   Time-to-digital converter measurement controller. Measures the interval
//   between an asynchronous start hit and an asynchronous stop hit as a coarse
//   clk cycle count plus two fine codes. Each fine code is the popcount of a
//   thermometer snapshot taken from an external delay chain in the cycle of
//   the corresponding edge. The result is held until the consumer accepts it
//   with a valid/ready handshake.
//
// Optional feature:
//   TDC_BUBBLE_FILTER_EN - when defined, every synchronised tap bit is replaced
//   by the 3-input majority of itself and its two neighbours (virtual bit -1 =
//   1, virtual bit NUM_TAPS = 0) before the popcount. The filter is purely
//   combinational, so it adds no latency. When undefined, the raw synchronised
//   taps are counted and no filter logic exists.
//
// Parameters:
//   NUM_TAPS  delay-chain taps (4..256)
//   COARSE_W  coarse counter width (4..32)
//   FINE_W    derived fine code width, $clog2(NUM_TAPS+1)
//
// Ports:
//   clk                in   single clock, rising edge
//   reset              in   asynchronous active-high reset, clears all state
//   start              in   asynchronous start hit
//   stop               in   asynchronous stop hit
//   taps               in   thermometer snapshot, bit 0 nearest the hit
//   result_valid       out  result held and available
//   result_ready       in   consumer accepts the result
//   result_coarse      out  clk cycles from start edge to stop edge
//   result_fine_start  out  fine code captured at the start edge
//   result_fine_stop   out  fine code captured at the stop edge
//   result_overflow    out  no stop edge before coarse saturation
//   busy               out  high while a measurement is running or held
//   missed_cnt         out  saturating count of start edges ignored when busy
// -----------------------------------------------------------------------------
module tdc_measure #(
  parameter  int NUM_TAPS = 32,
  parameter  int COARSE_W = 16,
  localparam int FINE_W   = $clog2(NUM_TAPS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [NUM_TAPS-1:0] taps,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [COARSE_W-1:0] result_coarse,
  output logic [FINE_W-1:0]   result_fine_start,
  output logic [FINE_W-1:0]   result_fine_stop,
  output logic                result_overflow,
  output logic                busy,
  output logic [7:0]          missed_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  genvar gi;

  // ---------------------------------------------------------------------------
  // Hit synchronisers and edge detection. Bit 0 = start, bit 1 = stop.
  // ---------------------------------------------------------------------------
  logic [1:0] hit_meta_q;
  logic [1:0] hit_s_q;
  logic [1:0] hit_prev_q;
  logic [1:0] hit_armed_q;
  logic [1:0] hit_armed_d;
  logic [1:0] hit_edge;
  logic [1:0] fill_q;
  logic [1:0] fill_d;
  logic       fill_done;

  // The synchroniser output is forced low by reset, which is not a genuine
  // observation of the input. fill_q waits out the two flop stages so that a
  // hit held high through reset is never mistaken for a fresh rising edge;
  // a channel only arms once a real low level has come through.
  assign fill_done = (fill_q == 2'd2);
  assign fill_d    = fill_done ? fill_q : fill_q + 2'd1;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_hit
      assign hit_armed_d[gi] = hit_armed_q[gi] | (fill_done & ~hit_s_q[gi]);
      assign hit_edge[gi]    = hit_armed_q[gi] & hit_s_q[gi] & ~hit_prev_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_meta_q  <= '0;
      hit_s_q     <= '0;
      hit_prev_q  <= '0;
      hit_armed_q <= '0;
      fill_q      <= '0;
    end else begin
      hit_meta_q  <= {stop, start};
      hit_s_q     <= hit_meta_q;
      hit_prev_q  <= hit_s_q;
      hit_armed_q <= hit_armed_d;
      fill_q      <= fill_d;
    end
  end

  logic start_edge;
  logic stop_edge;
  assign start_edge = hit_edge[0];
  assign stop_edge  = hit_edge[1];

  // ---------------------------------------------------------------------------
  // Tap synchroniser. Same depth as the hit path, so the taps seen in the edge
  // cycle are the ones sampled together with the hit.
  // ---------------------------------------------------------------------------
  logic [NUM_TAPS-1:0] taps_meta_q;
  logic [NUM_TAPS-1:0] taps_s_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taps_meta_q <= '0;
      taps_s_q    <= '0;
    end else begin
      taps_meta_q <= taps;
      taps_s_q    <= taps_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional bubble filter and popcount.
  // ---------------------------------------------------------------------------
  logic [NUM_TAPS-1:0] taps_f;

`ifdef TDC_BUBBLE_FILTER_EN
  // Pad with a 1 below bit 0 and a 0 above the top bit so the chain ends
  // behave like a clean thermometer boundary.
  logic [NUM_TAPS+1:0] taps_ext;
  assign taps_ext = {1'b0, taps_s_q, 1'b1};

  generate
    for (gi = 0; gi < NUM_TAPS; gi++) begin : g_bubble
      assign taps_f[gi] = (taps_ext[gi]   & taps_ext[gi+1]) |
                          (taps_ext[gi+1] & taps_ext[gi+2]) |
                          (taps_ext[gi]   & taps_ext[gi+2]);
    end
  endgenerate
`else
  assign taps_f = taps_s_q;
`endif

  function automatic logic [FINE_W-1:0] popcount(input logic [NUM_TAPS-1:0] v);
    logic [FINE_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      c = c + FINE_W'(v[i]);
    end
    return c;
  endfunction

  logic [FINE_W-1:0] fine_code;
  assign fine_code = popcount(taps_f);

  // ---------------------------------------------------------------------------
  // Measurement FSM with registered outputs.
  // cnt_q holds the number of cycles elapsed since the start edge; it is
  // loaded with 1 on entry to RUN so that in stop-edge cycle M it reads M-N.
  // Saturation is reached when it reads all-ones, which is also the last
  // cycle in which a stop edge still counts as a normal stop.
  // ---------------------------------------------------------------------------
  state_t              state_q;
  logic [COARSE_W-1:0] cnt_q;
  logic [COARSE_W-1:0] cnt_d;
  logic [7:0]          missed_q;
  logic [7:0]          missed_d;
  logic                valid_q;
  logic                busy_q;
  logic                overflow_q;
  logic [COARSE_W-1:0] coarse_q;
  logic [FINE_W-1:0]   fine_start_q;
  logic [FINE_W-1:0]   fine_stop_q;
  logic                cnt_sat;

  assign cnt_d    = cnt_q + COARSE_W'(1);
  assign cnt_sat  = (cnt_q == {COARSE_W{1'b1}});
  assign missed_d = (missed_q == 8'hFF) ? missed_q : missed_q + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      missed_q     <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      coarse_q     <= '0;
      fine_start_q <= '0;
      fine_stop_q  <= '0;
    end else begin
      // Start edges while a measurement is active are only counted.
      if (start_edge && (state_q != ST_IDLE)) begin
        missed_q <= missed_d;
      end

      case (state_q)
        ST_IDLE: begin
          // Stop edges are deliberately ignored here.
          if (start_edge) begin
            state_q      <= ST_RUN;
            busy_q       <= 1'b1;
            cnt_q        <= COARSE_W'(1);
            fine_start_q <= fine_code;
          end
        end

        ST_RUN: begin
          if (stop_edge) begin
            state_q     <= ST_DONE;
            valid_q     <= 1'b1;
            coarse_q    <= cnt_q;
            fine_stop_q <= fine_code;
            overflow_q  <= 1'b0;
          end else if (cnt_sat) begin
            state_q     <= ST_DONE;
            valid_q     <= 1'b1;
            coarse_q    <= {COARSE_W{1'b1}};
            fine_stop_q <= '0;
            overflow_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        ST_DONE: begin
          // valid_q is always high in DONE, so ready alone completes the
          // handshake; ready outside DONE has no effect.
          if (result_ready) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign result_valid      = valid_q;
  assign result_coarse     = coarse_q;
  assign result_fine_start = fine_start_q;
  assign result_fine_stop  = fine_stop_q;
  assign result_overflow   = overflow_q;
  assign busy              = busy_q;
  assign missed_cnt        = missed_q;

endmodule

// File: doc/tdc_measure.md
TDC_MEASURE -- requirements
Module: tdc_measure

Interface
REQ-001 NUM_TAPS, 32, number of delay-chain taps; legal range 4..256.
REQ-002 COARSE_W, 16, coarse counter width in bits; legal range 4..32.
REQ-003 FINE_W, $clog2(NUM_TAPS+1), fine code width; derived, not overridden.
REQ-004 clk  input  1  single clock; all state on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state.
REQ-006 start  input  1  asynchronous start hit.
REQ-007 stop  input  1  asynchronous stop hit.
REQ-008 taps  input  NUM_TAPS  thermometer snapshot from an external delay chain; bit 0 nearest the hit.
REQ-009 result_valid  output  1  result held and available.
REQ-010 result_ready  input  1  consumer accepts the result.
REQ-011 result_coarse  output  COARSE_W  clk cycles from start edge to stop edge.
REQ-012 result_fine_start  output  FINE_W  fine code captured at the start edge.
REQ-013 result_fine_stop  output  FINE_W  fine code captured at the stop edge.
REQ-014 result_overflow  output  1  no stop edge before coarse saturation.
REQ-015 busy  output  1  high in RUN or DONE.
REQ-016 missed_cnt  output  8  saturating count of start edges ignored outside IDLE.

Function
REQ-017 start, stop and taps SHALL each pass through a 2-flop synchroniser; all logic below uses the synchronised values (start_s, stop_s, taps_s).
REQ-018 Edge detect: an edge is detected in cycle N when the signal is 1 in N and 0 in N-1.
REQ-019 Fine code SHALL be the popcount of taps_s (after the optional filter) in the cycle of the edge.
REQ-020 FSM states: IDLE, RUN, DONE; reset state IDLE.
REQ-021 IDLE: a start edge in cycle N -> RUN; capture fine_start; coarse count = 0; stop edges are ignored in IDLE, including a stop edge in cycle N.
REQ-022 RUN: a stop edge in cycle M -> DONE with result_coarse = M-N, capture fine_stop, result_overflow = 0.
REQ-023 RUN: if no stop edge by cycle N+2^COARSE_W-1 -> DONE with result_coarse all-ones, fine_stop = 0, result_overflow = 1; a stop edge exactly in that cycle counts as a normal stop (overflow = 0).
REQ-024 DONE: result_valid = 1 from cycle M+1; all result_* stay stable until result_valid && result_ready.
REQ-025 On handshake -> IDLE next cycle; result_valid = 0 in that cycle; a start edge is accepted one cycle after the handshake cycle.
REQ-026 A start edge detected in RUN or DONE SHALL increment missed_cnt, saturating at 255, and SHALL not disturb the measurement.
REQ-027 result_ready while result_valid = 0 SHALL have no effect.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 Asserting reset SHALL, without a clock, force state IDLE, clear synchronisers, result_valid = 0, all result_* = 0, busy = 0, missed_cnt = 0.
REQ-030 Reset during RUN or DONE SHALL abort the measurement with no result emitted.
REQ-031 After reset deasserts, a start held high SHALL not be detected as an edge until it has been observed low.

Configuration
REQ-032 Macro TDC_BUBBLE_FILTER_EN defined: each taps_s bit SHALL be replaced by the majority of bits i-1, i, i+1, with virtual bit -1 = 1 and bit NUM_TAPS = 0, before popcount; the filter adds no latency.
REQ-033 Macro not defined: popcount of raw taps_s; no filter logic is present.

Verification
REQ-034 NUM_TAPS=8: taps=8'b0000_0111 at start, 8'b0001_1111 at stop, stop edge 10 cycles after start edge -> coarse=10, fine_start=3, fine_stop=5, overflow=0.
REQ-035 COARSE_W=4, no stop -> DONE 15 cycles after start edge: coarse=4'hF, overflow=1; repeated with stop edge at exactly +15 -> coarse=15, overflow=0.
REQ-036 result_ready held 0 for 20 cycles -> result_* stable, valid=1; 3 start edges during that time -> missed_cnt=3; ready pulse -> IDLE, new start accepted.
REQ-037 taps=8'b0000_1101 at the start edge -> fine_start=4 with TDC_BUBBLE_FILTER_EN, 3 without.
REQ-038 reset asserted mid-RUN with stop edge 2 cycles later -> no result_valid, busy=0, all outputs 0.
